// File: rtl/rand_stim_gen_pkg.sv
// Shared types, constants and helper functions for the rand_stim_gen stimulus source.
package rand_stim_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;
    localparam logic [31:0] ALT_PATTERN  = 32'h5555_5555;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Next set bit strictly above cur, wrapping; yields cur itself when it is the only set bit.
    function automatic logic [3:0] next_channel(input logic [15:0] mask, input logic [3:0] cur);
        logic [3:0] idx;
        logic [3:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = cur + 4'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rand_stim_gen_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load and step enable.
module lfsr32 import rand_stim_gen_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/rand_stim_gen.sv
// Burst stimulus generator: patterned words tagged with a round-robin channel over valid/ready.
module rand_stim_gen import rand_stim_gen_pkg::*; #(
    parameter int          DATA_W = 8,
    parameter int          CH_NUM = 4,
    parameter int          LEN_W  = 16,
    parameter logic [31:0] SEED   = DEFAULT_SEED,
    localparam int         CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [CH_NUM-1:0] ch_mask,
    output logic [DATA_W-1:0] dout,
    output logic [CH_W-1:0]   dout_ch,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_cnt
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CH_NUM-1:0]   mask_q, mask_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                lfsr_load;
    logic                lfsr_step;
    logic [31:0]         lfsr_q;
    logic                xfer;

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (SEED),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    assign xfer = valid_q & dout_ready;

    // dout holds the word being offered, so LFSR mode presents the post-step value on each transfer.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        ch_d      = ch_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode_e'(mode);
                    len_d     = burst_len;
                    mask_d    = ch_mask;
                    cnt_d     = '0;
                    lfsr_load = 1'b1;
                    if ((burst_len != '0) && (ch_mask != '0)) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        ch_d    = CH_W'(next_channel(16'(ch_mask), 4'hF));
                        case (mode_e'(mode))
                            MODE_INC:   dout_d = '0;
                            MODE_LFSR:  dout_d = DATA_W'(SEED);
                            MODE_WALK1: dout_d = DATA_W'(1);
                            default:    dout_d = DATA_W'(ALT_PATTERN);
                        endcase
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    cnt_d     = cnt_q + LEN_W'(1);
                    ch_d      = CH_W'(next_channel(16'(mask_q), 4'(ch_q)));
                    lfsr_step = (mode_q == MODE_LFSR);
                    case (mode_q)
                        MODE_INC:   dout_d = dout_q + DATA_W'(1);
                        MODE_LFSR:  dout_d = DATA_W'(lfsr_next(lfsr_q));
                        MODE_WALK1: dout_d = (dout_q << 1) | (dout_q >> (DATA_W - 1));
                        default:    dout_d = ~dout_q;
                    endcase
                    if ((cnt_q + LEN_W'(1)) == len_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_INC;
            len_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = ch_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_rand_stim_gen.sv
// Scoreboard bench for rand_stim_gen: directed bursts push expected words, a monitor pops and compares.
module tb_rand_stim_gen;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic [3:0]  ch_mask;
    logic [7:0]  dout;
    logic [1:0]  dout_ch;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;

    exp_t expQ[$];
    int   compared;
    int   mismatched;
    int   doneCount;

    rand_stim_gen #(
        .DATA_W (8),
        .CH_NUM (4),
        .LEN_W  (16),
        .SEED   (32'hACE1_2468)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .burst_len  (burst_len),
        .ch_mask    (ch_mask),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelLfsr(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic pushExp(input logic [7:0] d, input logic [1:0] ch);
        exp_t e;
        e.d  = d;
        e.ch = ch;
        expQ.push_back(e);
    endtask

    // Start is presented now and sampled at the next edge; inputs are scrambled afterwards.
    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] len, input logic [3:0] mask);
        mode      = m;
        burst_len = len;
        ch_mask   = mask;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        mode      = ~m;
        burst_len = 16'h0001;
        ch_mask   = 4'b0000;
    endtask

    task automatic waitDone(input int budget, input bit toggle, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (done) seen = 1'b1;
            else if (toggle) dout_ready = ~dout_ready;
        end
        checkOutput("done_seen", done, 1);
        if (seen) begin
            checkOutput("valid_at_done", dout_valid, 0);
            checkOutput("busy_at_done", busy, 0);
            @(posedge clk); #1;
            checkOutput("done_pulse_width", done, 0);
        end
        dout_ready = 1'b1;
    endtask

    // Monitor: pops on each transfer and checks that an offered-but-refused word stays stable.
    initial begin
        exp_t       e;
        bit         held;
        logic [7:0] heldD;
        logic [1:0] heldCh;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (done) doneCount++;
                if (held && dout_valid) begin
                    checkOutput("hold_data", dout, heldD);
                    checkOutput("hold_ch", dout_ch, heldCh);
                end
                held = 1'b0;
                if (dout_valid && dout_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_word", dout_valid, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("word_data", dout, e.d);
                        checkOutput("word_ch", dout_ch, e.ch);
                    end
                end else if (dout_valid) begin
                    held   = 1'b1;
                    heldD  = dout;
                    heldCh = dout_ch;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc;
        int          d0;
        logic [31:0] s;
        compared   = 0;
        mismatched = 0;
        doneCount  = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 2'd0;
        burst_len  = '0;
        ch_mask    = '0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_ch", dout_ch, 0);
        checkOutput("rst_valid", dout_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_word_cnt", word_cnt, 0);
        rst_n = 1'b1;

        $display("[TB] INC burst of 5 on all channels");
        for (int i = 0; i < 5; i++) pushExp(8'(i), 2'(i % 4));
        applyStimulus(2'd0, 16'd5, 4'b1111);
        checkOutput("inc_first_valid", dout_valid, 1);
        checkOutput("inc_first_busy", busy, 1);
        waitDone(50, 1'b0, cyc);
        checkOutput("inc_latency", cyc, 5);
        checkOutput("inc_word_cnt", word_cnt, 5);
        checkOutput("inc_leftover", expQ.size(), 0);

        $display("[TB] LFSR burst of 16 with toggling ready");
        s = 32'hACE1_2468;
        for (int i = 0; i < 16; i++) begin
            pushExp(s[7:0], 2'(i % 4));
            s = modelLfsr(s);
        end
        applyStimulus(2'd1, 16'd16, 4'b1111);
        checkOutput("lfsr_first", dout, 8'h68);
        waitDone(100, 1'b1, cyc);
        checkOutput("lfsr_word_cnt", word_cnt, 16);
        checkOutput("lfsr_leftover", expQ.size(), 0);

        $display("[TB] WALK1 burst of 4 on channels 1 and 3");
        pushExp(8'h01, 2'd1);
        pushExp(8'h02, 2'd3);
        pushExp(8'h04, 2'd1);
        pushExp(8'h08, 2'd3);
        applyStimulus(2'd2, 16'd4, 4'b1010);
        waitDone(50, 1'b0, cyc);
        checkOutput("walk_latency", cyc, 4);
        checkOutput("walk_word_cnt", word_cnt, 4);
        checkOutput("walk_leftover", expQ.size(), 0);

        $display("[TB] ALT burst of 3 on channel 2");
        pushExp(8'h55, 2'd2);
        pushExp(8'hAA, 2'd2);
        pushExp(8'h55, 2'd2);
        applyStimulus(2'd3, 16'd3, 4'b0100);
        waitDone(50, 1'b0, cyc);
        checkOutput("alt_word_cnt", word_cnt, 3);
        checkOutput("alt_leftover", expQ.size(), 0);

        $display("[TB] zero-length burst and empty channel mask");
        applyStimulus(2'd0, 16'd0, 4'b1111);
        checkOutput("zlen_done", done, 1);
        checkOutput("zlen_valid", dout_valid, 0);
        checkOutput("zlen_word_cnt", word_cnt, 0);
        @(posedge clk); #1;
        checkOutput("zlen_done_drop", done, 0);
        checkOutput("zlen_valid_after", dout_valid, 0);
        applyStimulus(2'd0, 16'd3, 4'b0000);
        checkOutput("zmask_done", done, 1);
        checkOutput("zmask_valid", dout_valid, 0);
        checkOutput("zmask_busy", busy, 0);
        @(posedge clk); #1;
        checkOutput("zmask_done_drop", done, 0);

        $display("[TB] reset after 3 transfers of an INC burst of 10");
        for (int i = 0; i < 3; i++) pushExp(8'(i), 2'(i));
        applyStimulus(2'd0, 16'd10, 4'b1111);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("mid_word_cnt", word_cnt, 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_rst_dout", dout, 0);
        checkOutput("mid_rst_ch", dout_ch, 0);
        checkOutput("mid_rst_valid", dout_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_word_cnt", word_cnt, 0);
        rst_n = 1'b1;
        checkOutput("mid_leftover", expQ.size(), 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("mid_idle_valid", dout_valid, 0);
        pushExp(8'h00, 2'd0);
        pushExp(8'h01, 2'd1);
        applyStimulus(2'd0, 16'd2, 4'b1111);
        checkOutput("restart_dout", dout, 8'h00);
        checkOutput("restart_ch", dout_ch, 0);
        waitDone(50, 1'b0, cyc);
        checkOutput("restart_latency", cyc, 2);
        checkOutput("restart_leftover", expQ.size(), 0);

        $display("[TB] INC burst of 258 with a stray start during RUN");
        for (int i = 0; i < 258; i++) pushExp(8'(i), 2'(i % 4));
        d0 = doneCount;
        applyStimulus(2'd0, 16'd258, 4'b1111);
        repeat (10) begin
            @(posedge clk); #1;
        end
        start     = 1'b1;
        mode      = 2'd1;
        burst_len = 16'd5;
        ch_mask   = 4'b0001;
        @(posedge clk); #1;
        start     = 1'b0;
        waitDone(400, 1'b0, cyc);
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("long_word_cnt", word_cnt, 258);
        checkOutput("long_done_pulses", doneCount - d0, 1);
        checkOutput("long_valid_idle", dout_valid, 0);
        checkOutput("long_leftover", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rand_stim_gen.md
# rand_stim_gen

Parametrised, synthesizable multi-channel stimulus generator. On a start pulse it emits a burst of `burst_len` data words over a valid/ready handshake. Words are tagged with a round-robin channel index. The word pattern is selected at start: incrementing, LFSR-random, walking-one or alternating. It drives DUT inputs in benches and on-board self-test paths, and replaces ad-hoc per-bench random loops with one reusable, deterministic source.

## Interface
Parameters:
- `DATA_W`, 8: output word width; legal 1..32.
- `CH_NUM`, 4: channel count; legal 1..16.
- `LEN_W`, 16: width of the burst length and word counter.
- `SEED`, 32'hACE1_2468: LFSR load value; must be nonzero.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: burst request; sampled only in IDLE.
- `mode` in 2: pattern select, latched at start. 0 = INC, 1 = LFSR, 2 = WALK1, 3 = ALT.
- `burst_len` in `LEN_W`: number of words in the burst, latched at start.
- `ch_mask` in `CH_NUM`: enabled channels, latched at start.
- `dout` out `DATA_W`: data word.
- `dout_ch` out max(1,$clog2(CH_NUM)): channel index of `dout`.
- `dout_valid` out 1: `dout`/`dout_ch` are valid.
- `dout_ready` in 1: consumer accepts; a transfer is `dout_valid & dout_ready`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at burst end.
- `word_cnt` out `LEN_W`: words accepted in the current or last burst.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start` when `burst_len` ≠ 0 and `ch_mask` ≠ 0.
- IDLE → DONE on `start` when `burst_len` = 0 or `ch_mask` = 0. No word is emitted.
- RUN → DONE on the transfer that makes `word_cnt` equal `burst_len`.
- DONE → IDLE unconditionally after one cycle.
- On start:
  - latch `mode`, `burst_len` and `ch_mask`;
  - clear `word_cnt`;
  - load LFSR with `SEED`;
  - set the pattern register to the mode's initial value: INC = 0, WALK1 = 1, ALT = 0x55… truncated to `DATA_W`.
- Per transfer:
  - `word_cnt` +1;
  - pattern advances: INC +1 modulo 2^`DATA_W`; WALK1 rotate left by 1; ALT bitwise invert;
  - LFSR steps once in LFSR mode only.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, tap mask 32'h8020_0003, shifting right. `dout` = lfsr[`DATA_W`-1:0].
- Channel selection:
  - the first word goes to the lowest set bit of the latched `ch_mask`;
  - each transfer advances to the next set bit above the current one, wrapping to the lowest.
- `start` in RUN or DONE is ignored. Inputs changing during RUN have no effect.
- `word_cnt` holds its final value until the next start.

## Timing
- Reset (`rst_n`=0 at a rising edge) puts everything to its reset value at that edge, including mid-burst: state IDLE, `dout`=0, `dout_ch`=0, `dout_valid`=0, `busy`=0, `done`=0, `word_cnt`=0. A new `start` is required afterwards.
- `start` sampled at edge N:
  - `dout_valid`=1 and `busy`=1 from cycle N+1;
  - the first word is already on `dout`.
- While `dout_valid`=1 and `dout_ready`=0, `dout` and `dout_ch` hold stable.
- Data throughput is one word per cycle when `dout_ready` is held high. No bubbles between words.
- After the final transfer at edge M:
  - at M+1, `dout_valid`=0, `busy`=0, `done`=1;
  - at M+2, `done`=0 and the FSM is in IDLE;
  - the earliest accepted restart is `start` sampled at M+2.
- Zero-length burst: `start` at N gives `done`=1 at N+1, and `dout_valid` stays 0 throughout.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `rand_stim_gen_pkg` holds:
  - the `mode_e` enum (INC/LFSR/WALK1/ALT);
  - the `state_e` enum (IDLE/RUN/DONE);
  - `LFSR_TAPS` = 32'h8020_0003;
  - `DEFAULT_SEED`.
- Sub-module `lfsr32` contains the LFSR register with ports `clk`, `rst_n`, `load`, `seed`, `step`, `q`.
- The channel search (next set bit above the current index, wrapping) is a function in the package.

## Test plan
- Mode INC, `burst_len`=5, `ch_mask`=4'b1111, ready held 1 → `dout` 00,01,02,03,04 on ch 0,1,2,3,0 on consecutive cycles; `done` one cycle after the last word; `word_cnt`=5.
- Mode LFSR, `burst_len`=16, ready toggling every cycle → first word 0x68; `dout` stable while ready is low; sequence matches a bench LFSR model; `word_cnt`=16.
- Mode WALK1, `ch_mask`=4'b1010, `burst_len`=4 → `dout` 01,02,04,08 on ch 1,3,1,3.
- `burst_len`=0, then separately `ch_mask`=0 → `dout_valid` never asserts; `done` at start+1.
- Reset asserted after 3 transfers of an INC burst of 10 → all outputs 0 at the next edge; a new start emits 00 again on ch 0.
- INC, `DATA_W`=8, `burst_len`=258, `start` pulsed during RUN → wrap FF→00 at word 256, last word 01, the extra start is ignored, exactly one `done` pulse.
